a1335_angle_poller: RTL and testbench

- Upstream sequencer and downstream consumer for the A1335 I2C angle-reader stage.
- Issues periodic one-cycle `read_angle` requests and presents `device_id`, cycling through NUM_SENSORS sensors at consecutive I2C addresses.
- Captures the 12-bit `angle` when the reader raises `done`, then unwraps it into a signed 32-bit multi-turn position per sensor.
- Provides per-sensor valid flags, a timeout error counter and a sample strobe for myo_control logic.

---
 rtl/a1335_angle_poller_if.sv | 28 ++
 rtl/a1335_angle_poller.sv | 191 +++++++++++++++++++
 tb/tb_a1335_angle_poller.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a1335_angle_poller_if.sv
// ----------------------------------------------------------------------------
// a1335_angle_poller_if
//
// Request/complete link between the angle poller (master) and the A1335 I2C
// angle reader (slave).
//
// Handshake: the master raises read_angle for exactly one clock to request a
// read of device_id. It only does this while done is high, because done high
// means the reader is idle. The reader acknowledges by dropping done. It
// raises done again when the transfer has finished. angle is valid for as
// long as done stays high after that completion. device_id does not change
// from the request until the result has been consumed.
//
// Signals:
//   read_angle  master->slave  one-cycle request pulse
//   device_id   master->slave  7-bit I2C address of the sensor being read
//   done        slave->master  high while the reader is idle / complete
//   angle       slave->master  12-bit angle result
// ----------------------------------------------------------------------------
interface a1335_angle_poller_if;
    logic        read_angle;
    logic [6:0]  device_id;
    logic        done;
    logic [11:0] angle;

    modport master (output read_angle, output device_id, input done, input angle);
    modport slave  (input read_angle, input device_id, output done, output angle);
endinterface

// File: rtl/a1335_angle_poller.sv
// ----------------------------------------------------------------------------
// a1335_angle_poller
//
// Polls NUM_SENSORS A1335 angle sensors at consecutive I2C addresses through
// the angle reader. The poller tracks each sensor's 12-bit angle and unwraps
// it into a signed 32-bit multi-turn position. Per-sensor valid flags, a
// saturating timeout counter and a one-cycle sample strobe are provided for
// the downstream control logic.
//
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   enable           polling enabled
//   period           cycles between successive request starts (0 = back-to-back)
//   rdr              reader link (master modport): read_angle, device_id, done, angle
//   position         signed positions, sensor i at [32i+31:32i]
//   valid            bit i set while sensor i holds a good sample
//   sample_strobe    one-cycle pulse when a position updates
//   sensor_index     sensor that was just updated, valid with sample_strobe
//   timeout_count    aborted transactions, saturating at 16'hFFFF
//   debug_state      current FSM state
// ----------------------------------------------------------------------------
module a1335_angle_poller #(
    parameter int         NUM_SENSORS    = 4,
    parameter logic [6:0] BASE_ADDR      = 7'h0C,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [31:0]                 period,
    a1335_angle_poller_if.master        rdr,
    output logic [32*NUM_SENSORS-1:0]   position,
    output logic [NUM_SENSORS-1:0]      valid,
    output logic                        sample_strobe,
    output logic [2:0]                  sensor_index,
    output logic [15:0]                 timeout_count,
    output logic [2:0]                  debug_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        UPDATE    = 3'd4,
        ABORT     = 3'd5,
        NEXT      = 3'd6
    } state_t;

    localparam logic [31:0] TMO_LOAD   = 32'(TIMEOUT_CYCLES);
    localparam logic [2:0]  LAST_INDEX = 3'(NUM_SENSORS - 1);

    state_t                      state;
    logic [2:0]                  index;
    logic [31:0]                 period_cnt;
    logic [31:0]                 tmo_cnt;
    logic [11:0]                 angle_cap;
    logic [12*NUM_SENSORS-1:0]   last_angle;
    logic                        read_angle_r;
    logic [6:0]                  device_id_r;

    logic [NUM_SENSORS-1:0]      sel_mask;
    logic [31:0]                 cur_pos;
    logic [11:0]                 cur_last;
    logic                        cur_valid;
    logic [11:0]                 delta;
    logic [31:0]                 upd_pos;
    logic [2:0]                  next_index;
    logic                        period_met;

    assign rdr.read_angle = read_angle_r;
    assign rdr.device_id  = device_id_r;
    assign debug_state    = state;

    assign sel_mask   = NUM_SENSORS'(1) << index;
    assign next_index = (index == LAST_INDEX) ? 3'd0 : index + 3'd1;

    // period_cnt holds the number of cycles since the last ISSUE. A NEXT
    // cycle with period_cnt+1 >= period therefore places the following ISSUE
    // exactly `period` cycles after the previous one.
    assign period_met = ({1'b0, period_cnt} + 33'd1) >= {1'b0, period};

    // Select the current sensor's stored state.
    always_comb begin
        cur_pos   = '0;
        cur_last  = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (sel_mask[i]) begin
                cur_pos   = position[32*i +: 32];
                cur_last  = last_angle[12*i +: 12];
                cur_valid = valid[i];
            end
        end
    end

    // Subtracting modulo 4096 and sign-extending gives the shortest signed
    // step across the 0/4095 wrap. A step of exactly half a turn reads as -2048.
    assign delta   = angle_cap - cur_last;
    assign upd_pos = cur_pos + {{20{delta[11]}}, delta};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            index         <= '0;
            period_cnt    <= '0;
            tmo_cnt       <= '0;
            angle_cap     <= '0;
            last_angle    <= '0;
            read_angle_r  <= 1'b0;
            device_id_r   <= BASE_ADDR;
            position      <= '0;
            valid         <= '0;
            sample_strobe <= 1'b0;
            sensor_index  <= '0;
            timeout_count <= '0;
        end else begin
            read_angle_r  <= 1'b0;
            sample_strobe <= 1'b0;
            if (state != IDLE && state != ISSUE && period_cnt != '1)
                period_cnt <= period_cnt + 32'd1;

            case (state)
                IDLE: begin
                    period_cnt <= '0;
                    if (enable && rdr.done) begin
                        read_angle_r <= 1'b1;
                        device_id_r  <= BASE_ADDR + {4'd0, index};
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt    <= TMO_LOAD;
                    period_cnt <= 32'd1;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!rdr.done) begin
                        tmo_cnt <= TMO_LOAD;
                        state   <= WAIT_DONE;
                    end else if (tmo_cnt <= 32'd1) begin
                        state <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (rdr.done) begin
                        angle_cap <= rdr.angle;
                        state     <= UPDATE;
                    end else if (tmo_cnt <= 32'd1) begin
                        state <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < NUM_SENSORS; i++) begin
                        if (sel_mask[i]) begin
                            position[32*i +: 32]   <= cur_valid ? upd_pos : {20'd0, angle_cap};
                            last_angle[12*i +: 12] <= angle_cap;
                        end
                    end
                    valid         <= valid | sel_mask;
                    sample_strobe <= 1'b1;
                    sensor_index  <= index;
                    index         <= next_index;
                    state         <= NEXT;
                end
                ABORT: begin
                    valid <= valid & ~sel_mask;
                    if (timeout_count != 16'hFFFF)
                        timeout_count <= timeout_count + 16'd1;
                    index <= next_index;
                    state <= NEXT;
                end
                NEXT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (period_met && rdr.done) begin
                        read_angle_r <= 1'b1;
                        device_id_r  <= BASE_ADDR + {4'd0, index};
                        state        <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a1335_angle_poller.sv
// ----------------------------------------------------------------------------
// tb_a1335_angle_poller
//
// Bench for a1335_angle_poller. It uses two instances:
//   dut     NUM_SENSORS=2, TIMEOUT_CYCLES=200, driven by a behavioural reader
//   dut_to  NUM_SENSORS=2, TIMEOUT_CYCLES=20, whose reader never acknowledges
// A combined reader/scoreboard process answers the requests from dut. It
// unwraps every delivered angle with plain integer arithmetic and queues the
// expected {sensor, position} pair. Each sample_strobe is then compared
// against that queue.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_a1335_angle_poller;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic        enable, enable_to;
    logic [31:0] period, period_to;
    logic [63:0] position, position_to;
    logic [1:0]  valid, valid_to;
    logic        sample_strobe, sample_strobe_to;
    logic [2:0]  sensor_index, sensor_index_to;
    logic [15:0] timeout_count, timeout_count_to;
    logic [2:0]  debug_state, debug_state_to;

    a1335_angle_poller_if rif();
    a1335_angle_poller_if rif_to();

    a1335_angle_poller #(.NUM_SENSORS(2), .BASE_ADDR(7'h0C), .TIMEOUT_CYCLES(200)) dut (
        .clock(clock), .reset(reset), .enable(enable), .period(period), .rdr(rif),
        .position(position), .valid(valid), .sample_strobe(sample_strobe),
        .sensor_index(sensor_index), .timeout_count(timeout_count), .debug_state(debug_state)
    );

    a1335_angle_poller #(.NUM_SENSORS(2), .BASE_ADDR(7'h0C), .TIMEOUT_CYCLES(20)) dut_to (
        .clock(clock), .reset(reset), .enable(enable_to), .period(period_to), .rdr(rif_to),
        .position(position_to), .valid(valid_to), .sample_strobe(sample_strobe_to),
        .sensor_index(sensor_index_to), .timeout_count(timeout_count_to), .debug_state(debug_state_to)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pulse  = 0;
    int n_strobe = 0;
    int s0_updates = 0;
    int last_pulse_cyc = 0;
    logic [6:0] last_pulse_dev = '0;

    // reader behaviour knobs
    int busy_len      = 50;
    int default_angle = 100;   // negative selects a random angle
    bit ext_busy      = 1'b0;
    int s0_q[$];
    int s1_q[$];

    // reference model
    logic signed [31:0] m_pos [2];
    bit   [1:0]         m_valid;
    int                 m_last [2];
    int                 m_idx;
    logic [34:0]        exp_q[$];

    // ---------------- reader model + scoreboard ----------------
    initial begin : reader_scoreboard
        int rd_phase;
        int rd_cnt;
        int a;
        int d;
        int ei;
        logic [34:0] e;
        rd_phase = 0;
        rd_cnt   = 0;
        rif.done  = 1'b1;
        rif.angle = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                rd_phase = 0;
                rd_cnt   = 0;
                rif.done = 1'b1;
                m_idx    = 0;
                m_valid  = '0;
                for (int i = 0; i < 2; i++) begin
                    m_pos[i]  = '0;
                    m_last[i] = 0;
                end
                exp_q.delete();
            end else begin
                if (rif.read_angle) begin
                    n_pulse++;
                    last_pulse_cyc = cyc;
                    last_pulse_dev = rif.device_id;
                    n_checks++;
                    if (rif.device_id !== 7'(12 + m_idx)) begin
                        n_fail++;
                        $display("FAIL sb_device_id: got 0x%0h expected 0x%0h", rif.device_id, 7'(12 + m_idx));
                    end
                end
                if (sample_strobe) begin
                    n_strobe++;
                    if (sensor_index == 3'd0) s0_updates++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_strobe: got unexpected strobe for sensor %0d, expected none", sensor_index);
                    end else begin
                        e  = exp_q.pop_front();
                        ei = int'(e[34:32]);
                        if (sensor_index !== e[34:32] || position[32*ei +: 32] !== e[31:0] || valid[ei] !== 1'b1) begin
                            n_fail++;
                            $display("FAIL sb_update: got sensor %0d pos %0d valid %b, expected sensor %0d pos %0d valid 1",
                                     sensor_index, $signed(position[32*ei +: 32]), valid, e[34:32], $signed(e[31:0]));
                        end
                    end
                end
                case (rd_phase)
                    1: begin
                        rif.done = 1'b0;
                        rd_cnt   = busy_len;
                        rd_phase = 2;
                    end
                    2: begin
                        rd_cnt--;
                        if (rd_cnt <= 0) begin
                            if (m_idx == 0 && s0_q.size() > 0)      a = s0_q.pop_front();
                            else if (m_idx == 1 && s1_q.size() > 0) a = s1_q.pop_front();
                            else if (default_angle < 0)             a = int'($urandom_range(0, 4095));
                            else                                    a = default_angle;
                            if (!m_valid[m_idx]) begin
                                m_pos[m_idx] = a;
                            end else begin
                                d = ((a - m_last[m_idx]) % 4096 + 4096) % 4096;
                                if (d >= 2048) d = d - 4096;
                                m_pos[m_idx] = m_pos[m_idx] + d;
                            end
                            m_valid[m_idx] = 1'b1;
                            m_last[m_idx]  = a;
                            exp_q.push_back({3'(m_idx), m_pos[m_idx]});
                            m_idx     = (m_idx + 1) % 2;
                            rif.angle = 12'(a);
                            rif.done  = 1'b1;
                            rd_phase  = 0;
                        end
                    end
                    default: begin
                        rif.done = !ext_busy;
                        if (rif.read_angle) rd_phase = 1;
                    end
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock); #1;
        reset = 1'b1; enable = 1'b0; enable_to = 1'b0;
        period = '0; period_to = '0; ext_busy = 1'b0;
        s0_q.delete(); s1_q.delete();
        @(negedge clock); @(negedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string tag);
        int k = 0;
        while (n_strobe < target && k < budget) begin @(negedge clock); #1; k++; end
        n_checks++;
        if (n_strobe < target) begin
            n_fail++;
            $display("FAIL %s: got %0d strobes, expected %0d within %0d cycles", tag, n_strobe, target, budget);
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int k = 0;
        while (n_pulse < target && k < budget) begin @(negedge clock); #1; k++; end
        n_checks++;
        if (n_pulse < target) begin
            n_fail++;
            $display("FAIL %s: got %0d pulses, expected %0d within %0d cycles", tag, n_pulse, target, budget);
        end
    endtask

    task automatic wait_s0(input int target, input int budget, input string tag);
        int k = 0;
        while (s0_updates < target && k < budget) begin @(negedge clock); #1; k++; end
        n_checks++;
        if (s0_updates < target) begin
            n_fail++;
            $display("FAIL %s: got %0d sensor0 updates, expected %0d", tag, s0_updates, target);
        end
    endtask

    task automatic finish_txns(input string tag);
        enable = 1'b0;
        idle_wait(150);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending updates, expected 0", tag, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; enable_to = 1'b0; period = '0; period_to = '0;
        rif_to.done = 1'b1; rif_to.angle = 12'd0;
        repeat (3) @(negedge clock);
        #1;
        n_checks++; if (rif.read_angle !== 1'b0) begin n_fail++; $display("FAIL rst_read_angle: got %b expected 0", rif.read_angle); end
        n_checks++; if (rif.device_id !== 7'h0C) begin n_fail++; $display("FAIL rst_device_id: got 0x%0h expected 0x0c", rif.device_id); end
        n_checks++; if (position !== 64'd0) begin n_fail++; $display("FAIL rst_position: got 0x%0h expected 0", position); end
        n_checks++; if (valid !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b expected 00", valid); end
        n_checks++; if (sample_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %b expected 0", sample_strobe); end
        n_checks++; if (sensor_index !== 3'd0) begin n_fail++; $display("FAIL rst_sensor_index: got %0d expected 0", sensor_index); end
        n_checks++; if (timeout_count !== 16'd0) begin n_fail++; $display("FAIL rst_timeout_count: got %0d expected 0", timeout_count); end
        n_checks++; if (rif_to.read_angle !== 1'b0 || timeout_count_to !== 16'd0) begin n_fail++; $display("FAIL rst_to: got ra %b tc %0d expected 0 0", rif_to.read_angle, timeout_count_to); end
        @(negedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int bs, bp;
        do_reset();
        busy_len = 50; default_angle = 100;
        bs = n_strobe; bp = n_pulse;
        enable = 1'b1;
        wait_strobes(bs + 2, 400, "basic_strobes");
        n_checks++; if (valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid: got %b expected 11", valid); end
        n_checks++; if (position[31:0] !== 32'd100) begin n_fail++; $display("FAIL basic_pos0: got %0d expected 100", position[31:0]); end
        n_checks++; if (position[63:32] !== 32'd100) begin n_fail++; $display("FAIL basic_pos1: got %0d expected 100", position[63:32]); end
        finish_txns("basic");
        n_checks++;
        if ((n_pulse - bp) != (n_strobe - bs)) begin
            n_fail++;
            $display("FAIL basic_pulse_per_txn: got %0d pulses for %0d strobes, expected equal", n_pulse - bp, n_strobe - bs);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        busy_len = 4; default_angle = -1;
        s0_q.push_back(4000); s0_q.push_back(96); s0_q.push_back(0);
        enable = 1'b1;
        wait_s0(s0_updates + 1, 200, "wrap_first");
        n_checks++; if (position[31:0] !== 32'd4000) begin n_fail++; $display("FAIL wrap_pos_4000: got %0d expected 4000", $signed(position[31:0])); end
        wait_s0(s0_updates + 1, 200, "wrap_second");
        n_checks++; if (position[31:0] !== 32'd4192) begin n_fail++; $display("FAIL wrap_pos_4192: got %0d expected 4192", $signed(position[31:0])); end
        wait_s0(s0_updates + 1, 200, "wrap_third");
        n_checks++; if (position[31:0] !== 32'd4096) begin n_fail++; $display("FAIL wrap_pos_4096: got %0d expected 4096", $signed(position[31:0])); end
        finish_txns("wrap");
    endtask

    task automatic test_half_turn();
        do_reset();
        busy_len = 3; default_angle = -1;
        s0_q.push_back(0); s0_q.push_back(2048); s0_q.push_back(0);
        enable = 1'b1;
        wait_s0(s0_updates + 1, 200, "half_first");
        n_checks++; if (position[31:0] !== 32'd0) begin n_fail++; $display("FAIL half_pos_0: got %0d expected 0", $signed(position[31:0])); end
        wait_s0(s0_updates + 1, 200, "half_second");
        n_checks++; if (position[31:0] !== 32'hFFFF_F800) begin n_fail++; $display("FAIL half_pos_m2048: got %0d expected -2048", $signed(position[31:0])); end
        wait_s0(s0_updates + 1, 200, "half_third");
        finish_txns("half");
    endtask

    task automatic test_random();
        int bs;
        do_reset();
        busy_len = int'($urandom_range(2, 20)); default_angle = -1;
        period = $urandom_range(0, 80);
        bs = n_strobe;
        enable = 1'b1;
        wait_strobes(bs + 6, 1500, "random_a");
        period = $urandom_range(0, 80);
        busy_len = int'($urandom_range(2, 20));
        wait_strobes(bs + 14, 2000, "random_b");
        finish_txns("random");
    endtask

    task automatic test_period();
        int bp, t1, t2;
        do_reset();
        busy_len = 1; default_angle = 7;
        period = 32'd1000;
        bp = n_pulse;
        enable = 1'b1;
        wait_pulses(bp + 1, 20, "period_first");
        t1 = last_pulse_cyc;
        wait_pulses(bp + 2, 1100, "period_second");
        t2 = last_pulse_cyc;
        n_checks++; if (t2 - t1 != 1000) begin n_fail++; $display("FAIL period_gap1: got %0d cycles expected 1000", t2 - t1); end
        wait_pulses(bp + 3, 1100, "period_third");
        n_checks++; if (last_pulse_cyc - t2 != 1000) begin n_fail++; $display("FAIL period_gap2: got %0d cycles expected 1000", last_pulse_cyc - t2); end
        finish_txns("period");
    endtask

    task automatic test_busy_gate();
        int bp;
        do_reset();
        busy_len = 5; default_angle = 300;
        ext_busy = 1'b1;
        idle_wait(2);
        bp = n_pulse;
        enable = 1'b1;
        idle_wait(40);
        n_checks++; if (n_pulse != bp) begin n_fail++; $display("FAIL busy_gate_hold: got %0d pulses expected 0", n_pulse - bp); end
        ext_busy = 1'b0;
        wait_pulses(bp + 1, 10, "busy_gate_release");
        finish_txns("busy_gate");
    endtask

    task automatic test_enable_mid();
        int bs, bp;
        do_reset();
        busy_len = 30; default_angle = 200;
        bs = n_strobe; bp = n_pulse;
        enable = 1'b1;
        wait_pulses(bp + 1, 20, "en_mid_first");
        idle_wait(10);
        enable = 1'b0;
        idle_wait(100);
        n_checks++; if (n_strobe - bs != 1) begin n_fail++; $display("FAIL en_mid_complete: got %0d strobes expected 1", n_strobe - bs); end
        n_checks++; if (n_pulse - bp != 1) begin n_fail++; $display("FAIL en_mid_no_reissue: got %0d pulses expected 1", n_pulse - bp); end
        enable = 1'b1;
        wait_pulses(bp + 2, 20, "en_mid_resume");
        n_checks++; if (last_pulse_dev !== 7'h0D) begin n_fail++; $display("FAIL en_mid_index_kept: got 0x%0h expected 0x0d", last_pulse_dev); end
        wait_strobes(bs + 2, 100, "en_mid_second");
        finish_txns("en_mid");
    endtask

    task automatic test_timeout();
        int k, t0, extra;
        do_reset();
        rif_to.done = 1'b1; rif_to.angle = 12'd0;
        enable_to = 1'b1;
        k = 0;
        while (!rif_to.read_angle && k < 10) begin @(negedge clock); #1; k++; end
        n_checks++; if (rif_to.device_id !== 7'h0C || !rif_to.read_angle) begin n_fail++; $display("FAIL to_first_req: got ra %b dev 0x%0h expected 1 0x0c", rif_to.read_angle, rif_to.device_id); end
        t0 = cyc; extra = 0; k = 0;
        while (timeout_count_to == 16'd0 && k < 60) begin
            @(negedge clock); #1; k++;
            if (rif_to.read_angle) extra++;
        end
        n_checks++; if (timeout_count_to !== 16'd1) begin n_fail++; $display("FAIL to_count1: got %0d expected 1", timeout_count_to); end
        n_checks++; if (cyc - t0 < 21 || cyc - t0 > 23) begin n_fail++; $display("FAIL to_latency: got %0d cycles expected 21..23", cyc - t0); end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL to_single_pulse: got %0d extra pulses expected 0", extra); end
        n_checks++; if (valid_to !== 2'b00 || position_to !== 64'd0) begin n_fail++; $display("FAIL to_valid: got %b pos 0x%0h expected 00 0", valid_to, position_to); end
        k = 0;
        while (!rif_to.read_angle && k < 10) begin @(negedge clock); #1; k++; end
        n_checks++; if (rif_to.device_id !== 7'h0D || !rif_to.read_angle) begin n_fail++; $display("FAIL to_advance: got ra %b dev 0x%0h expected 1 0x0d", rif_to.read_angle, rif_to.device_id); end
        k = 0;
        while (timeout_count_to == 16'd1 && k < 60) begin @(negedge clock); #1; k++; end
        n_checks++; if (timeout_count_to !== 16'd2) begin n_fail++; $display("FAIL to_count2: got %0d expected 2", timeout_count_to); end
        enable_to = 1'b0;
        idle_wait(40);
    endtask

    task automatic test_reset_mid();
        int bs, bp;
        do_reset();
        busy_len = 50; default_angle = 100;
        bs = n_strobe; bp = n_pulse;
        enable = 1'b1;
        wait_strobes(bs + 2, 400, "rmid_strobes");
        wait_pulses(bp + 3, 100, "rmid_third_req");
        idle_wait(20);
        n_checks++; if (valid !== 2'b11) begin n_fail++; $display("FAIL rmid_pre_valid: got %b expected 11", valid); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (rif.read_angle !== 1'b0) begin n_fail++; $display("FAIL rmid_read_angle: got %b expected 0", rif.read_angle); end
        n_checks++; if (position !== 64'd0) begin n_fail++; $display("FAIL rmid_position: got 0x%0h expected 0", position); end
        n_checks++; if (valid !== 2'b00) begin n_fail++; $display("FAIL rmid_valid: got %b expected 00", valid); end
        n_checks++; if (timeout_count !== 16'd0 || sample_strobe !== 1'b0) begin n_fail++; $display("FAIL rmid_misc: got tc %0d strobe %b expected 0 0", timeout_count, sample_strobe); end
        @(negedge clock); @(negedge clock); #1;
        bp = n_pulse;
        reset = 1'b0;
        wait_pulses(bp + 1, 20, "rmid_restart");
        n_checks++; if (last_pulse_dev !== 7'h0C) begin n_fail++; $display("FAIL rmid_first_dev: got 0x%0h expected 0x0c", last_pulse_dev); end
        finish_txns("rmid");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        enable = 1'b0; enable_to = 1'b0; period = '0; period_to = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_half_turn();
        test_random();
        test_period();
        test_busy_gate();
        test_enable_mid();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
